m_kbd_evq: RTL and testbench

Parametrised keyboard event queue between a byte-level keyboard front-end (PS/2 receiver or CH559 serial receiver) and the virtio-input device logic. It decodes PS/2 set-2 prefix sequences (F0 break, E0 extended, E1 pause) into 16-bit key events and buffers them in a power-of-two FIFO. It optionally suppresses typematic repeats, drops controller response bytes, and paces service requests to the micro-controller. It replaces the fixed 16-entry, F0-only queue and the mtime-mask request pacing.

---
 rtl/m_kbd_evq_pkg.sv | 41 ++++
 rtl/m_kbd_evq_fifo.sv | 67 ++++++
 rtl/m_kbd_evq.sv | 193 +++++++++++++++++++
 tb/tb_m_kbd_evq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_kbd_evq_pkg.sv
// Shared constants for the keyboard event queue: event layout, PS/2 set-2 prefix bytes, decoder states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package m_kbd_evq_pkg;

    // Event word bit positions; [15:10] are always zero, [7:0] is the scan code.
    localparam int EV_EXT   = 9;
    localparam int EV_PRESS = 8;

    // PS/2 set-2 prefix bytes.
    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_E1 = 8'hE1;
    localparam logic [7:0] PFX_F0 = 8'hF0;

    // Controller response bytes: ack, BAT ok, echo, resend.
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT    = 8'hAA;
    localparam logic [7:0] RSP_ECHO   = 8'hEE;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    // Error / buffer-overrun bytes from the keyboard.
    localparam logic [7:0] BYTE_ERR0 = 8'h00;
    localparam logic [7:0] BYTE_ERR1 = 8'hFF;

    // Pause sends E1 followed by seven bytes; it is reported as one extended 0x77 press.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } dec_state_t;

    function automatic logic is_response(input logic [7:0] b);
        return (b == RSP_ACK) || (b == RSP_BAT) || (b == RSP_ECHO) || (b == RSP_RESEND);
    endfunction

endpackage

// File: rtl/m_kbd_evq_fifo.sv
// First-word-fall-through DEPTH x 16 event FIFO with explicit occupancy count and synchronous clear.
// Latency: push at t is visible at the head at t+1 when empty; pop at t advances the head at t+1.
// Backpressure: none upstream; a push while full without a same-cycle pop is dropped and flagged on w_drop.
module m_evq_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     w_clear,
    input  logic                     w_push,
    input  logic [15:0]              w_push_data,
    input  logic                     w_pop,
    output logic                     w_valid,
    output logic [15:0]              w_data,
    output logic [$clog2(DEPTH):0]   w_count,
    output logic                     w_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop while full frees the slot the push needs; a pop while empty is ignored.
    assign push_ok = w_push && (!full || w_pop) && !w_clear;
    assign pop_ok  = w_pop && !empty && !w_clear;
    assign w_drop  = w_push && full && !w_pop && !w_clear;

    assign w_valid = !empty;
    assign w_data  = empty ? 16'h0000 : mem[rd_ptr];
    assign w_count = count;

    // Pointer and occupancy update; clear wins over push/pop. Pointers wrap naturally (power-of-two depth).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (w_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are never read while empty so no reset is needed.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= w_push_data;
    end

endmodule

// File: rtl/m_kbd_evq.sv
// Decodes PS/2 set-2 bytes into 16-bit key events, filters repeats/responses, queues them and paces service requests.
// Latency: byte at t -> event at FIFO head at t+1 (when empty); w_req registered, at least one cycle after w_ev_valid rises.
// Backpressure: none upstream; events arriving at a full queue are dropped and counted in w_ovf_cnt (saturating).
module m_kbd_evq
    import m_kbd_evq_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int REQ_GAP     = 262144,
    parameter int DROP_REPEAT = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     w_rx_en,
    input  logic [7:0]               w_rx_data,
    input  logic                     w_enable,
    input  logic                     w_clear,
    input  logic                     w_pop,
    output logic                     w_ev_valid,
    output logic [15:0]              w_ev_data,
    output logic [$clog2(DEPTH):0]   w_count,
    output logic                     w_req,
    output logic [7:0]               w_ovf_cnt
);
    localparam int              GW       = $clog2(REQ_GAP + 1);
    localparam logic [GW-1:0]   GAP_LOAD = GW'(REQ_GAP - 1);

    dec_state_t    state;
    dec_state_t    state_n;
    logic [2:0]    skip;
    logic [2:0]    skip_n;
    logic          ev_emit;
    logic          ev_ext;
    logic          ev_press;
    logic [7:0]    ev_code;
    logic          err_byte;

    logic [511:0]  key_map;
    logic [8:0]    map_idx;
    logic          repeat_hit;
    logic          ev_push;
    logic [15:0]   ev_word;
    logic          fifo_drop;

    logic          outstanding;
    logic [GW-1:0] gap_cnt;
    logic          req_fire;

    // Decoder state register; clear and reset both abandon any prefix in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            skip  <= '0;
        end else if (w_clear) begin
            state <= ST_IDLE;
            skip  <= '0;
        end else begin
            state <= state_n;
            skip  <= skip_n;
        end
    end

    // Prefix decoding: next state and the event (if any) produced by the current byte.
    always_comb begin
        state_n  = state;
        skip_n   = skip;
        ev_emit  = 1'b0;
        ev_ext   = 1'b0;
        ev_press = 1'b0;
        ev_code  = w_rx_data;
        err_byte = 1'b0;
        if (w_rx_en) begin
            if ((w_rx_data == BYTE_ERR0) || (w_rx_data == BYTE_ERR1)) begin
                err_byte = 1'b1;
                state_n  = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (w_rx_data == PFX_E0) begin
                            state_n = ST_EXT;
                        end else if (w_rx_data == PFX_F0) begin
                            state_n = ST_BRK;
                        end else if (w_rx_data == PFX_E1) begin
                            state_n = ST_PAUSE;
                            skip_n  = PAUSE_SKIP;
                        end else if (!is_response(w_rx_data)) begin
                            ev_emit  = 1'b1;
                            ev_press = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (w_rx_data == PFX_F0) begin
                            state_n = ST_EXT_BRK;
                        end else begin
                            ev_emit  = 1'b1;
                            ev_ext   = 1'b1;
                            ev_press = 1'b1;
                            state_n  = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        ev_emit = 1'b1;
                        state_n = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        ev_emit = 1'b1;
                        ev_ext  = 1'b1;
                        state_n = ST_IDLE;
                    end
                    ST_PAUSE: begin
                        skip_n = skip - 3'd1;
                        if (skip == 3'd1) begin
                            ev_emit  = 1'b1;
                            ev_ext   = 1'b1;
                            ev_press = 1'b1;
                            ev_code  = PAUSE_CODE;
                            state_n  = ST_IDLE;
                        end
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end
    end

    // Pause never sends a release, so its bitmap bit stays set until clear/reset.
    assign map_idx    = {ev_ext, ev_code};
    assign repeat_hit = (DROP_REPEAT != 0) && ev_press && key_map[map_idx];
    assign ev_push    = ev_emit && !repeat_hit;

    always_comb begin
        ev_word           = 16'h0000;
        ev_word[7:0]      = ev_code;
        ev_word[EV_EXT]   = ev_ext;
        ev_word[EV_PRESS] = ev_press;
    end

    // Key-down bitmap tracks every decoded event, including ones the queue later drops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_map <= '0;
        end else if (w_clear) begin
            key_map <= '0;
        end else if (ev_emit) begin
            key_map[map_idx] <= ev_press;
        end
    end

    m_evq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .w_clear     (w_clear),
        .w_push      (ev_push),
        .w_push_data (ev_word),
        .w_pop       (w_pop),
        .w_valid     (w_ev_valid),
        .w_data      (w_ev_data),
        .w_count     (w_count),
        .w_drop      (fifo_drop)
    );

    // Saturating count of lost events and error bytes (the two cannot coincide on one byte).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_ovf_cnt <= '0;
        end else if (w_clear) begin
            w_ovf_cnt <= '0;
        end else if ((err_byte || fifo_drop) && (w_ovf_cnt != 8'hFF)) begin
            w_ovf_cnt <= w_ovf_cnt + 8'd1;
        end
    end

    assign req_fire = w_enable && w_ev_valid && !outstanding && (gap_cnt == '0);

    // Request pacing: one pulse per pop, and pulses at least REQ_GAP cycles apart.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_req       <= 1'b0;
            outstanding <= 1'b0;
            gap_cnt     <= '0;
        end else if (w_clear) begin
            w_req       <= 1'b0;
            outstanding <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            w_req <= req_fire;
            if (req_fire)   outstanding <= 1'b1;
            else if (w_pop) outstanding <= 1'b0;
            if (req_fire)              gap_cnt <= GAP_LOAD;
            else if (gap_cnt != '0)    gap_cnt <= gap_cnt - GW'(1);
        end
    end

endmodule

// File: tb/tb_m_kbd_evq.sv
// Scoreboard bench for m_kbd_evq: stimulus pushes expected events, a monitor checks every handshaked pop.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench pops explicitly; DEPTH=4 exercises overflow and push+pop at full.
module tb_m_kbd_evq;
    localparam int DEPTH   = 4;
    localparam int REQ_GAP = 8;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic                   w_rx_en = 1'b0;
    logic [7:0]             w_rx_data = 8'h00;
    logic                   w_enable = 1'b0;
    logic                   w_clear = 1'b0;
    logic                   w_pop = 1'b0;
    logic                   w_ev_valid;
    logic [15:0]            w_ev_data;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_req;
    logic [7:0]             w_ovf_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          req_cnt  = 0;
    int          last_req_cyc = 0;
    logic [15:0] exp_q[$];

    m_kbd_evq #(.DEPTH(DEPTH), .REQ_GAP(REQ_GAP), .DROP_REPEAT(1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .w_rx_en    (w_rx_en),
        .w_rx_data  (w_rx_data),
        .w_enable   (w_enable),
        .w_clear    (w_clear),
        .w_pop      (w_pop),
        .w_ev_valid (w_ev_valid),
        .w_ev_data  (w_ev_data),
        .w_count    (w_count),
        .w_req      (w_req),
        .w_ovf_cnt  (w_ovf_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial forever begin
        @(negedge CLK);
        if (w_req) begin
            req_cnt++;
            last_req_cyc = cyc;
        end
    end

    // Monitor: every accepted pop must match the oldest expected event.
    initial forever begin
        @(negedge CLK);
        if (!RST && !w_clear && w_pop && w_ev_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected no event", w_ev_data);
            end else begin
                chk("pop_head", 32'(w_ev_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        w_rx_en   = 1'b1;
        w_rx_data = b;
        @(posedge CLK);
        #1;
        w_rx_en   = 1'b0;
    endtask

    task automatic pop1();
        w_pop = 1'b1;
        @(posedge CLK);
        #1;
        w_pop = 1'b0;
    endtask

    task automatic clear1();
        w_clear = 1'b1;
        @(posedge CLK);
        #1;
        w_clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2 * DEPTH + 2 && w_ev_valid; i++) pop1();
        chk({name, "_empty"}, 32'(w_ev_valid), 32'd0);
        chk({name, "_scoreboard_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, 32'(w_ev_valid), 32'd0);
        chk({name, "_data"},  32'(w_ev_data),  32'd0);
        chk({name, "_count"}, 32'(w_count),    32'd0);
        chk({name, "_req"},   32'(w_req),      32'd0);
        chk({name, "_ovf"},   32'(w_ovf_cnt),  32'd0);
    endtask

    initial begin
        logic [7:0] presses [6];
        int r0;
        int t1;
        int t2;
        int w;
        presses = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

        // Reset state
        #22;
        chk_all_zero("reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick(1);

        // Make/break of a plain key, one request while outstanding
        w_enable = 1'b1;
        r0 = req_cnt;
        send(8'h1C); exp_q.push_back(16'h011C);
        chk("t1_valid_next_cycle", 32'(w_ev_valid), 32'd1);
        chk("t1_head_press", 32'(w_ev_data), 32'h011C);
        send(8'hF0);
        send(8'h1C); exp_q.push_back(16'h001C);
        chk("t1_count2", 32'(w_count), 32'd2);
        tick(12);
        chk("t1_one_req", 32'(req_cnt - r0), 32'd1);
        w_enable = 1'b0;
        drain("t1");

        // Extended make/break and Pause
        clear1();
        send(8'hE0); send(8'h75); exp_q.push_back(16'h0375);
        send(8'hE0); send(8'hF0); send(8'h75); exp_q.push_back(16'h0275);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); exp_q.push_back(16'h0377);
        chk("t2_count3", 32'(w_count), 32'd3);
        drain("t2");

        // Repeat suppression, response bytes, error byte
        clear1();
        repeat (5) send(8'h1C);
        exp_q.push_back(16'h011C);
        send(8'hF0); send(8'h1C); exp_q.push_back(16'h001C);
        send(8'hFA); send(8'hAA);
        chk("t3_count2", 32'(w_count), 32'd2);
        chk("t3_ovf0", 32'(w_ovf_cnt), 32'd0);
        send(8'h00);
        chk("t3_ovf_err", 32'(w_ovf_cnt), 32'd1);
        chk("t3_count_after_err", 32'(w_count), 32'd2);
        drain("t3");

        // Overflow at DEPTH=4, then push+pop at full
        clear1();
        for (int i = 0; i < 6; i++) begin
            send(presses[i]);
            if (i < DEPTH) exp_q.push_back({8'h01, presses[i]});
        end
        chk("t4_count_full", 32'(w_count), 32'd4);
        chk("t4_ovf2", 32'(w_ovf_cnt), 32'd2);
        chk("t4_head_first", 32'(w_ev_data), 32'h0115);
        w_rx_en = 1'b1; w_rx_data = 8'h3C; w_pop = 1'b1;
        exp_q.push_back(16'h013C);
        @(posedge CLK);
        #1;
        w_rx_en = 1'b0; w_pop = 1'b0;
        chk("t4_count_stays_full", 32'(w_count), 32'd4);
        chk("t4_ovf_unchanged", 32'(w_ovf_cnt), 32'd2);
        chk("t4_head_advanced", 32'(w_ev_data), 32'h011D);
        drain("t4");

        // Request spacing and enable gating
        clear1();
        w_enable = 1'b1;
        r0 = req_cnt;
        send(8'h1C); exp_q.push_back(16'h011C);
        send(8'h1D); exp_q.push_back(16'h011D);
        send(8'h24); exp_q.push_back(16'h0124);
        w = 0;
        while (req_cnt == r0 && w < 30) begin tick(1); w++; end
        chk("t5_first_req_seen", 32'(req_cnt - r0), 32'd1);
        t1 = last_req_cyc;
        tick(1);
        pop1();
        w = 0;
        while (req_cnt < r0 + 2 && w < 30) begin tick(1); w++; end
        chk("t5_second_req_seen", 32'(req_cnt - r0), 32'd2);
        t2 = last_req_cyc;
        chk("t5_gap_at_least_8", 32'((t2 - t1) >= REQ_GAP), 32'd1);
        tick(12);
        chk("t5_no_req_before_pop", 32'(req_cnt - r0), 32'd2);
        w_enable = 1'b0;
        drain("t5");
        clear1();
        r0 = req_cnt;
        send(8'h2C); send(8'h35);
        tick(20);
        chk("t5_disabled_no_req", 32'(req_cnt - r0), 32'd0);
        chk("t5_disabled_count", 32'(w_count), 32'd2);
        exp_q.push_back(16'h012C);
        exp_q.push_back(16'h0135);
        drain("t5b");

        // Asynchronous reset mid-prefix, then clear with a populated queue
        clear1();
        send(8'h00); send(8'h2C); send(8'hE0); send(8'hF0);
        chk("t6_pre_count", 32'(w_count), 32'd1);
        chk("t6_pre_ovf", 32'(w_ovf_cnt), 32'd1);
        #3;
        RST = 1'b1;
        #1;
        chk_all_zero("t6_in_reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick(1);
        send(8'h1C); exp_q.push_back(16'h011C);
        chk("t6_after_reset_head", 32'(w_ev_data), 32'h011C);
        chk("t6_after_reset_count", 32'(w_count), 32'd1);
        drain("t6");
        send(8'h15); send(8'h1D); send(8'h24);
        chk("t6_count3", 32'(w_count), 32'd3);
        clear1();
        chk("t6_clear_count", 32'(w_count), 32'd0);
        chk("t6_clear_valid", 32'(w_ev_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
